// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions used by the ALU, the control unit and the
// multi-cycle multiply/divide unit.
//   DEF_WIDTH  : default datapath width
//   ALU_MUL    : opcode for signed multiply
//   ALU_DIV    : opcode for signed divide
//   md_state_t : mul/div sequencer states
//   is_md_op() : true for an opcode the mul/div unit accepts
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [4:0] ALU_MUL = 5'b01111;
    localparam logic [4:0] ALU_DIV = 5'b10000;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_ITER,
        MD_FIN,
        MD_DONE
    } md_state_t;

    function automatic logic is_md_op(input logic [4:0] op);
        return (op == ALU_MUL) || (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// -----------------------------------------------------------------------------
// mul_div_unit_if
// Request/response bundle between the control unit (master) and the
// multiply/divide unit (slave).
//   start, alu_control, a, b        : request, master -> slave
//   busy, done, result, div_by_zero : status/result, slave -> master
// -----------------------------------------------------------------------------
interface mul_div_unit_if #(
    parameter int WIDTH = cpu_pkg::DEF_WIDTH
) ();

    logic                 start;
    logic [4:0]           alu_control;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;
    logic                 div_by_zero;

    modport master (
        output start, alu_control, a, b,
        input  busy, done, result, div_by_zero
    );

    modport slave (
        input  start, alu_control, a, b,
        output busy, done, result, div_by_zero
    );

endinterface

// File: rtl/md_addsub.sv
// -----------------------------------------------------------------------------
// md_addsub
// W-bit adder/subtractor: sum_o = sub_i ? x_i - y_i : x_i + y_i.
// One carry chain serves the Booth step, the non-restoring step and the
// remainder restore.
//   x_i, y_i : operands
//   sub_i    : 1 selects subtraction
//   sum_o    : result, modulo 2^W
// -----------------------------------------------------------------------------
module md_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic         sub_i,
    output logic [W-1:0] sum_o
);

    // Two's-complement subtract as invert-and-carry-in on a single adder.
    assign sum_o = x_i + (y_i ^ {W{sub_i}}) + W'(sub_i);

endmodule

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Multi-cycle signed multiply / divide, radix-2, one step per clock.
//   MUL : full 2*WIDTH-bit signed product (Booth recoding).
//   DIV : non-restoring division on magnitudes, then sign fix-up;
//         result = {remainder, quotient}, quotient truncates toward zero.
// Ports:
//   clk : clock, rising edge
//   clr : asynchronous active-low reset
//   md  : slave side of mul_div_unit_if (start/alu_control/a/b in,
//         busy/done/result/div_by_zero out, all outputs registered)
// Latency: start accepted in cycle N -> done in N+WIDTH+2
//          (N+2 for divide by zero).
// -----------------------------------------------------------------------------
module mul_div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 6          // 2**CNT_W must exceed WIDTH
) (
    input  logic            clk,
    input  logic            clr,
    mul_div_unit_if.slave   md
);

    localparam int AW = WIDTH + 1;

    md_state_t            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 is_div_q;
    logic                 dz_q;        // current DIV has a zero divisor
    logic                 q1_q;        // Booth q(-1) bit
    logic                 neg_q_q;     // quotient must be negated
    logic                 neg_r_q;     // remainder must be negated
    logic [AW-1:0]        acc_q;       // MUL: high accumulator, DIV: partial remainder
    logic [WIDTH-1:0]     mq_q;        // MUL: multiplier, DIV: dividend -> quotient
    logic [WIDTH-1:0]     opb_q;       // MUL: multiplicand, DIV: divisor magnitude
    logic                 busy_q;
    logic                 done_q;
    logic                 dbz_q;
    logic [2*WIDTH-1:0]   result_q;

    // ---------------------------------------------------------------------
    // Request decode (IDLE only)
    // ---------------------------------------------------------------------
    logic             div_req;
    logic             b_zero;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign div_req = (md.alu_control == ALU_DIV);
    assign b_zero  = (md.b == '0);
    // Magnitude of the most negative value is 2^(WIDTH-1), still exact unsigned.
    assign a_mag   = md.a[WIDTH-1] ? -md.a : md.a;
    assign b_mag   = md.b[WIDTH-1] ? -md.b : md.b;

    // ---------------------------------------------------------------------
    // Shared adder operand select
    // ---------------------------------------------------------------------
    logic [AW-1:0] as_x;
    logic [AW-1:0] as_y;
    logic          as_sub;
    logic [AW-1:0] as_sum;

    always_comb begin
        // Default covers the FIN restore: remainder + divisor.
        as_x   = acc_q;
        as_y   = {1'b0, opb_q};
        as_sub = 1'b0;
        if (state_q == MD_ITER) begin
            if (is_div_q) begin
                // Shift next dividend bit in; subtract while remainder >= 0.
                as_x   = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
                as_sub = ~acc_q[WIDTH];
            end else begin
                // Booth pair 10 subtracts, 01 adds; 00/11 bypass below.
                as_y   = {opb_q[WIDTH-1], opb_q};
                as_sub = mq_q[0];
            end
        end
    end

    md_addsub #(.W(AW)) u_addsub (
        .x_i   (as_x),
        .y_i   (as_y),
        .sub_i (as_sub),
        .sum_o (as_sum)
    );

    logic [AW-1:0] booth_acc;
    assign booth_acc = (mq_q[0] ^ q1_q) ? as_sum : acc_q;

    // ---------------------------------------------------------------------
    // FIN correction
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] fin_res;

    always_comb begin
        rem     = acc_q[WIDTH] ? as_sum[WIDTH-1:0] : acc_q[WIDTH-1:0];
        fin_res = {acc_q[WIDTH-1:0], mq_q};
        if (is_div_q) begin
            if (dz_q)
                fin_res = {mq_q, {WIDTH{1'b1}}};
            else
                fin_res = {neg_r_q ? -rem : rem, neg_q_q ? -mq_q : mq_q};
        end
    end

    // ---------------------------------------------------------------------
    // Sequencer with registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            q1_q     <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            acc_q    <= '0;
            mq_q     <= '0;
            opb_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MD_IDLE: begin
                    if (md.start && is_md_op(md.alu_control)) begin
                        is_div_q <= div_req;
                        dz_q     <= div_req && b_zero;
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        q1_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        dbz_q    <= 1'b0;
                        neg_q_q  <= md.a[WIDTH-1] ^ md.b[WIDTH-1];
                        neg_r_q  <= md.a[WIDTH-1];
                        if (div_req) begin
                            opb_q   <= b_mag;
                            // Divide by zero returns the raw dividend as remainder.
                            mq_q    <= b_zero ? md.a : a_mag;
                            state_q <= b_zero ? MD_FIN : MD_ITER;
                        end else begin
                            opb_q   <= md.a;
                            mq_q    <= md.b;
                            state_q <= MD_ITER;
                        end
                    end
                end
                MD_ITER: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (is_div_q) begin
                        acc_q <= as_sum;
                        mq_q  <= {mq_q[WIDTH-2:0], ~as_sum[WIDTH]};
                    end else begin
                        // Arithmetic right shift of {acc, multiplier, q-1}.
                        acc_q <= {booth_acc[WIDTH], booth_acc[WIDTH:1]};
                        mq_q  <= {booth_acc[0], mq_q[WIDTH-1:1]};
                        q1_q  <= mq_q[0];
                    end
                    if (cnt_q == CNT_W'(WIDTH - 1))
                        state_q <= MD_FIN;
                end
                MD_FIN: begin
                    result_q <= fin_res;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    dbz_q    <= dz_q;
                    state_q  <= MD_DONE;
                end
                MD_DONE: begin
                    state_q <= MD_IDLE;
                end
                default: begin
                    state_q <= MD_IDLE;
                end
            endcase
        end
    end

    assign md.busy        = busy_q;
    assign md.done        = done_q;
    assign md.result      = result_q;
    assign md.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
    import cpu_pkg::*;

    logic        clk;
    logic        clr;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] last_res;

    mul_div_unit_if #(.WIDTH(32)) mdif ();

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .clr (clr),
        .md  (mdif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: signed arithmetic in 64 bits, truncating division.
    function automatic logic [63:0] ref_md(input logic [4:0] op, input logic [31:0] av,
                                           input logic [31:0] bv);
        longint sa, sb, q, r;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        if (op == ALU_MUL) return sa * sb;
        if (bv == 32'd0) return {av, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0, 1: return $urandom;
            2:    return 32'($urandom_range(0, 40)) - 32'd20;
            3:    return 32'h8000_0000;
            4:    return 32'hFFFF_FFFF;
            default: return 32'($urandom_range(0, 3));
        endcase
    endfunction

    // Issue one operation from a negedge, follow it to done.
    // poke >= 2: re-pulse start with other operands in cycle N+poke.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input int poke);
        logic [63:0] exp;
        int          lat;
        int          k;
        bit          seen;
        exp  = ref_md(op, av, bv);
        lat  = (op == ALU_DIV && bv == 32'd0) ? 2 : 34;
        seen = 1'b0;
        mdif.start       = 1'b1;
        mdif.alu_control = op;
        mdif.a           = av;
        mdif.b           = bv;
        for (k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (mdif.done) begin
                seen = 1'b1;
                break;
            end
            if (k == 1) begin
                mdif.start = 1'b0;
                mdif.a     = $urandom;
                mdif.b     = $urandom;
                chk({tag, " busy"}, 64'(mdif.busy), 64'd1);
                chk({tag, " dbz_clr"}, 64'(mdif.div_by_zero), 64'd0);
                chk({tag, " res_hold"}, mdif.result, last_res);
            end
            if (k == poke) begin
                mdif.start       = 1'b1;
                mdif.alu_control = ALU_MUL;
                mdif.a           = $urandom;
                mdif.b           = $urandom;
            end else if (k == poke + 1) begin
                mdif.start = 1'b0;
            end
        end
        if (!seen) begin
            chk({tag, " done_timeout"}, 64'd0, 64'd1);
        end else begin
            chk({tag, " latency"}, 64'(k), 64'(lat));
            chk({tag, " result"}, mdif.result, exp);
            chk({tag, " dbz"}, 64'(mdif.div_by_zero), 64'(op == ALU_DIV && bv == 32'd0));
            chk({tag, " busy_done"}, 64'(mdif.busy), 64'd0);
            @(negedge clk);
            chk({tag, " done_pulse"}, 64'(mdif.done), 64'd0);
            chk({tag, " res_after"}, mdif.result, exp);
        end
        mdif.start = 1'b0;
        last_res   = exp;
    endtask

    initial begin
        int ndone;
        mdif.start       = 1'b0;
        mdif.alu_control = 5'd0;
        mdif.a           = '0;
        mdif.b           = '0;
        clr              = 1'b0;
        last_res         = '0;
        #1;
        chk("rst busy", 64'(mdif.busy), 64'd0);
        chk("rst done", 64'(mdif.done), 64'd0);
        chk("rst result", mdif.result, 64'd0);
        chk("rst dbz", 64'(mdif.div_by_zero), 64'd0);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op("mul7x-3", ALU_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 0);
        chk("mul7x-3 exact", last_res, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mul_min2", ALU_MUL, 32'h8000_0000, 32'h8000_0000, 0);
        chk("mul_min2 exact", last_res, 64'h4000_0000_0000_0000);
        run_op("div-7/2", ALU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 0);
        chk("div-7/2 exact", last_res, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_wrap", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("div_wrap exact", last_res, 64'h0000_0000_8000_0000);
        run_op("div5/0", ALU_DIV, 32'h0000_0005, 32'h0000_0000, 0);
        chk("div5/0 exact", last_res, 64'h0000_0005_FFFF_FFFF);

        // Start while busy is ignored
        run_op("mul_poke", ALU_MUL, 32'd100, 32'd100, 5);
        chk("mul_poke exact", last_res, 64'd10000);

        // Reset in the middle of an operation
        mdif.start       = 1'b1;
        mdif.alu_control = ALU_MUL;
        mdif.a           = 32'd123;
        mdif.b           = 32'd456;
        @(negedge clk);
        mdif.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort busy_before", 64'(mdif.busy), 64'd1);
        clr = 1'b0;
        #1;
        chk("abort busy", 64'(mdif.busy), 64'd0);
        chk("abort done", 64'(mdif.done), 64'd0);
        chk("abort result", mdif.result, 64'd0);
        chk("abort dbz", 64'(mdif.div_by_zero), 64'd0);
        @(negedge clk);
        clr      = 1'b1;
        last_res = '0;
        ndone    = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mdif.done) ndone++;
        end
        chk("abort no_done", 64'(ndone), 64'd0);

        // Invalid opcode stays idle
        mdif.start       = 1'b1;
        mdif.alu_control = 5'b00001;
        mdif.a           = 32'd9;
        mdif.b           = 32'd3;
        @(negedge clk);
        mdif.start = 1'b0;
        chk("badop busy", 64'(mdif.busy), 64'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mdif.done || mdif.busy) ndone++;
        end
        chk("badop idle", 64'(ndone), 64'd0);
        chk("badop result", mdif.result, 64'd0);

        // Randomized operations
        for (int t = 0; t < 40; t++) begin
            logic [4:0]  op;
            logic [31:0] av, bv;
            op = $urandom_range(0, 1) ? ALU_MUL : ALU_DIV;
            av = pick();
            bv = pick();
            run_op($sformatf("rnd%0d", t), op, av, bv, ($urandom_range(0, 3) == 0) ? 7 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
